// File: rtl/fifo_burst_reader_if.sv
// Bundle between the burst reader and its source FIFOs / packet buffer.
// master = reader side, slave = FIFO/buffer side.
interface fifo_burst_reader_if #(
  parameter int NCH    = 5,
  parameter int ADDR_W = $clog2(NCH)
);
  logic              full;
  logic [NCH-1:0]    empty;
  logic              eth_en;
  logic [NCH-1:0]    rd_en;
  logic [ADDR_W-1:0] addr;
  logic              burst_done;

  modport master (
    input  full,
    input  empty,
    output eth_en,
    output rd_en,
    output addr,
    output burst_done
  );

  modport slave (
    output full,
    output empty,
    input  eth_en,
    input  rd_en,
    input  addr,
    input  burst_done
  );
endinterface

// File: rtl/fifo_burst_reader.sv
// Bursty multi-channel FIFO drainer: READ bursts separated by PAUSE gaps.
// Define FIFO_BURST_READER_RR_EN for round-robin, else fixed priority.
module fifo_burst_reader #(
  parameter int NCH       = 5,
  parameter int BURST_LEN = 1024,
  parameter int PAUSE_LEN = 8192,
  parameter int CNT_W     = 16,
  parameter int ADDR_W    = $clog2(NCH)
) (
  input logic            clk,
  input logic            rstn,
  fifo_burst_reader_if.master bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;

  localparam logic [CNT_W-1:0] BURST_END =
    CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] PAUSE_END =
    CNT_W'(PAUSE_LEN - 1);

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic              any_data;
  logic              sel_vld;
  logic [ADDR_W-1:0] sel_idx;

  assign any_data = ~&bus.empty;

`ifdef FIFO_BURST_READER_RR_EN
  logic [ADDR_W-1:0] ptr;
  int unsigned       rr_j;

  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    rr_j    = 0;
    for (int i = 0; i < NCH; i++) begin
      rr_j = (int'(ptr) + i) % NCH;
      if (!sel_vld && !bus.empty[rr_j]) begin
        sel_vld = 1'b1;
        sel_idx = ADDR_W'(rr_j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr <= '0;
    end else if (state == READ && sel_vld) begin
      if (sel_idx == ADDR_W'(NCH - 1))
        ptr <= '0;
      else
        ptr <= sel_idx + 1'b1;
    end
  end
`else
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (!bus.empty[i]) begin
        sel_vld = 1'b1;
        sel_idx = ADDR_W'(i);
      end
    end
  end
`endif

  // Loss of data aborts to IDLE ahead of either terminal count.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (bus.full && any_data)
            state <= READ;
        end
        READ: begin
          if (!any_data) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == BURST_END) begin
            state <= PAUSE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PAUSE: begin
          if (!any_data) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == PAUSE_END) begin
            state <= READ;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Outputs are held quiet while reset is asserted.
  always_comb begin
    bus.eth_en     = 1'b0;
    bus.rd_en      = '0;
    bus.addr       = '0;
    bus.burst_done = 1'b0;
    if (rstn) begin
      unique case (state)
        READ: begin
          bus.eth_en = 1'b1;
          if (sel_vld) begin
            bus.rd_en = NCH'(1) << sel_idx;
            bus.addr  = sel_idx;
          end
          bus.burst_done = any_data && (cnt == BURST_END);
        end
        PAUSE: begin
          bus.addr = sel_idx;
        end
        default: begin
          bus.eth_en = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed plus random checks of fifo_burst_reader against a burst-level model.
// Honors FIFO_BURST_READER_RR_EN for the expected channel selection.
module tb_fifo_burst_reader;

  localparam int NCH   = 5;
  localparam int BLEN  = 4;
  localparam int PLEN  = 3;

  logic clk = 1'b0;
  logic rstn;
  int   checks = 0;
  int   errors = 0;

  // model: mode 0=idle 1=bursting 2=waiting
  int m_mode  = 0;
  int m_reads = 0;
  int m_wait  = 0;
  int m_next  = 0;

  fifo_burst_reader_if #(.NCH(NCH)) bus ();

  fifo_burst_reader #(
    .NCH(NCH), .BURST_LEN(BLEN), .PAUSE_LEN(PLEN), .CNT_W(16)
  ) dut (
    .clk(clk), .rstn(rstn), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic int pick(logic [NCH-1:0] e, int from);
    for (int i = 0; i < NCH; i++) begin
      int c;
      c = (from + i) % NCH;
      if (!e[c]) return c;
    end
    return -1;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(logic r, logic f, logic [NCH-1:0] e);
    int g;
    int start;
    logic [31:0] x_eth, x_rd, x_addr, x_bd;
    @(negedge clk);
    rstn = r;
    bus.full = f;
    bus.empty = e;
`ifdef FIFO_BURST_READER_RR_EN
    start = m_next;
`else
    start = 0;
`endif
    g = pick(e, start);
    x_eth = 0; x_rd = 0; x_addr = 0; x_bd = 0;
    if (r) begin
      if (m_mode == 1) begin
        x_eth = 1;
        if (g >= 0) begin
          x_rd = 32'(1) << g;
          x_addr = 32'(g);
          x_bd = (m_reads == BLEN - 1) ? 1 : 0;
        end
      end else if (m_mode == 2 && g >= 0) begin
        x_addr = 32'(g);
      end
    end
    #1;
    chk("eth_en", 32'(bus.eth_en), x_eth);
    chk("rd_en", 32'(bus.rd_en), x_rd);
    chk("addr", 32'(bus.addr), x_addr);
    chk("burst_done", 32'(bus.burst_done), x_bd);
    chk("rd_en_vs_empty", 32'(bus.rd_en & e), 32'd0);
    @(posedge clk);
    if (!r) begin
      m_mode = 0; m_reads = 0; m_wait = 0; m_next = 0;
    end else if (m_mode != 0 && g < 0) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      if (f && g >= 0) begin
        m_mode = 1; m_reads = 0;
      end
    end else if (m_mode == 1) begin
      m_next = (g + 1) % NCH;
      m_reads++;
      if (m_reads == BLEN) begin
        m_mode = 2; m_wait = 0;
      end
    end else begin
      m_wait++;
      if (m_wait == PLEN) begin
        m_mode = 1; m_reads = 0;
      end
    end
  endtask

  task automatic run(int n, logic f, logic [NCH-1:0] e);
    for (int i = 0; i < n; i++) step(1'b1, f, e);
  endtask

  initial begin
    logic [NCH-1:0] re;
    rstn = 1'b0;
    bus.full = 1'b0;
    bus.empty = '1;
    step(1'b0, 1'b1, 5'b11110);
    step(1'b0, 1'b1, 5'b11110);
    // single-channel burst, pause, next burst
    run(12, 1'b1, 5'b11110);
    run(1, 1'b1, 5'b11111);
    // no data or no trigger keeps it idle
    run(5, 1'b1, 5'b11111);
    run(5, 1'b0, 5'b00000);
    // multi-channel arbitration
    run(10, 1'b1, 5'b01100);
    run(1, 1'b0, 5'b11111);
    // data vanishes on the second read
    run(2, 1'b1, 5'b11110);
    run(2, 1'b0, 5'b11111);
    // data vanishes on the last read of a burst
    run(4, 1'b1, 5'b11101);
    run(2, 1'b1, 5'b11111);
    // reset in the middle of the pause
    run(7, 1'b1, 5'b10011);
    step(1'b0, 1'b1, 5'b10011);
    run(6, 1'b1, 5'b10011);
    // full ignored outside idle
    run(8, 1'b0, 5'b00101);
    run(1, 1'b0, 5'b11111);
    for (int i = 0; i < 600; i++) begin
      re = ($urandom_range(0, 9) == 0) ? 5'b11111
                                       : NCH'($urandom);
      step($urandom_range(0, 49) != 0,
           $urandom_range(0, 2) != 0, re);
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
